ctrl_pipe: RTL
==============

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter: STAGES, 5, number of pipeline control stages (IF/ID/EX/MEM/WB); legal range 2..16.
REQ-002 Parameter: DATA_W, 32, width of the packed control payload carried per stage.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  in  1  new control word offered to stage 0.
REQ-006 Port: in_data  in  DATA_W  payload offered to stage 0.
REQ-007 Port: in_ready  out  1  stage 0 accepts on this edge; equals !hold[0].
REQ-008 Port: stall  in  STAGES  per-stage stall request; bit 0 = youngest stage.
REQ-009 Port: flush  in  STAGES  per-stage flush request; flush[j] kills stages 0..j.
REQ-010 Port: out_valid  out  1  stage STAGES-1 holds a valid word.
REQ-011 Port: out_data  out  DATA_W  payload of stage STAGES-1.
REQ-012 Port: stage_valid  out  STAGES  valid bit of every stage.
REQ-013 Port: occupancy  out  $clog2(STAGES+1)  count of valid stages.
REQ-014 Port: bubble_cnt  out  16  saturating count of stall-bubble cycles.

Function
REQ-015 Stage 0 youngest, stage STAGES-1 oldest; out_valid/out_data are stage STAGES-1 registers directly (no output logic).
REQ-016 hold[k] = OR of stall[k..STAGES-1]; a held stage keeps valid and data unchanged.
REQ-017 kill[k] = OR of flush[k..STAGES-1]; killed stage's content is treated as bubble by its consumer.
REQ-018 Non-held stage k>0 loads stage k-1 content, except it loads bubble if hold[k-1] is set or stage k-1 is killed.
REQ-019 Non-held stage 0 loads in_valid/in_data; in_valid=0 or kill[0]=1 loads bubble (input discarded).
REQ-020 Bubble = valid 0, data all zeros; data of every invalid stage is always zero.
REQ-021 Flush beats stall: any stage k with kill[k]=1 becomes invalid on the next edge even if hold[k]=1.
REQ-022 Latency with no stall/flush: word accepted on edge N appears on out_data after edge N+STAGES-1; throughput one word per cycle.
REQ-023 Last stage retires every cycle it is not held; no downstream handshake.
REQ-024 occupancy = popcount(stage_valid), derived only from registered valid bits.
REQ-025 bubble_cnt increments by 1 on an edge where any k has hold[k-1]=1, hold[k]=0 and stage k-1 valid and not killed; saturates at 0xFFFF.
REQ-026 Stall with all-zero bits and flush all-zero: pure shift register.

Reset
REQ-027 reset=1 clears all stage valid bits, stage data, and bubble_cnt immediately, independent of clk.
REQ-028 During reset: out_valid=0, out_data=0, stage_valid=0, occupancy=0, bubble_cnt=0; in_ready=!hold[0].
REQ-029 First edge after reset release behaves as a normal edge; no warm-up cycle.

Structure
REQ-030 STAGES default, DATA_W default and the bubble (nop) payload constant live in the shared lc3b_types package.
REQ-031 One sub-module ctrl_pipe_stage (one valid+data register with hold/kill/bubble-select) instantiated STAGES times by generate.

Verification
REQ-032 Reset, stream in_data=1..8 valid each cycle, no stall/flush -> out_data=1 after 5th edge from acceptance, then 2..8 consecutively; occupancy=5 steady.
REQ-033 Full pipe 10..14 (stage4=10), stall[2]=1 one cycle -> stages 0..2 hold, stage3=bubble, in_ready=0, bubble_cnt 0->1, output shows one invalid gap.
REQ-034 Full pipe, flush[1]=1 one cycle -> stages 0..2 invalid, stages 3,4 = old stages 2,3, in_data discarded, occupancy=2.
REQ-035 Full pipe, flush[1]=1 and stall[3]=1 together -> stages 0,1 invalid, stages 2,3 unchanged, stage4=bubble, bubble_cnt +1.
REQ-036 Toggle stall[1] for 140000 cycles -> bubble_cnt reaches and holds 0xFFFF.
REQ-037 Assert reset between clk edges mid-stream -> all outputs zero before next edge; restream of 1..8 matches REQ-032.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared pipeline-control defaults: stage count, payload width and the
// bubble (nop) payload loaded into every invalid stage.
package lc3b_types;

  localparam int STAGES_DEFAULT = 5;
  localparam int DATA_W_DEFAULT = 32;

  localparam logic [DATA_W_DEFAULT-1:0] NOP_DATA = '0;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline control stage: a valid+payload register that either holds,
// is killed to a bubble, or loads the (already bubble-gated) upstream word.
module ctrl_pipe_stage
  import lc3b_types::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              kill,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_DATA);

  // Kill is checked before hold so a flushed stage empties even while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (kill) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (!hold) begin
      valid <= src_valid;
      data  <= src_valid ? src_data : BUBBLE;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Stallable, flushable control pipeline; stage 0 is youngest and the oldest
// stage drives the outputs directly. Also counts stall-induced bubbles.
module ctrl_pipe
  import lc3b_types::*;
#(
  parameter int STAGES = STAGES_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [STAGES-1:0]            stage_valid,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [15:0]                  bubble_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic [DATA_W-1:0] stage_data [STAGES];
  logic              bubble_event;

  // A stall or flush at stage k also freezes or empties everything younger.
  always_comb begin
    hold = '0;
    kill = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold[k] = |(stall >> k);
      kill[k] = |(flush >> k);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              src_valid;
    logic [DATA_W-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = stage_valid[k-1] & ~hold[k-1] & ~kill[k-1];
      assign src_data  = stage_data[k-1];
    end

    ctrl_pipe_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .hold     (hold[k]),
      .kill     (kill[k]),
      .src_valid(src_valid),
      .src_data (src_data),
      .valid    (stage_valid[k]),
      .data     (stage_data[k])
    );
  end

  assign in_ready  = ~hold[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(stage_valid[k]);
    end
  end

  // A bubble is born at the hold boundary when a live word is left behind it.
  always_comb begin
    bubble_event = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      if (hold[k-1] && !hold[k] && stage_valid[k-1] && !kill[k-1]) begin
        bubble_event = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (bubble_event && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule
